// File: rtl/icdf_pkg.sv
// rtl/icdf_pkg.sv - shared types and constants for the inverse-CDF scheduler
package icdf_pkg;

   // Default slice geometry; the scheduler checks its own parameters against these.
   localparam int ICDF_NREQ  = 4;
   localparam int ICDF_WIDTH = 32;
   localparam int FRAC       = 16;
   localparam int IDW        = $clog2(ICDF_NREQ);

   // One half in Q16.16
   localparam logic signed [ICDF_WIDTH-1:0] HALF = 32'sd32768;

   // Tag carried alongside a sample while it is inside the pipeline
   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } icdf_tag_t;

   // Retired result: requester id plus z-score
   typedef struct packed {
      logic [IDW-1:0]        id;
      logic [ICDF_WIDTH-1:0] z;
   } icdf_res_t;

   localparam int RESW = $bits(icdf_res_t);

endpackage

// File: rtl/icdf_result_fifo.sv
// rtl/icdf_result_fifo.sv - synchronous result FIFO with count-based full/empty
module icdf_result_fifo
   import icdf_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [RESW-1:0] push_data,
   input  logic            pop,
   output logic [RESW-1:0] head,
   output logic            empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [RESW-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   count_q, count_d;
   logic            full, push_ok, pop_ok;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_q[rd_q];

   // Occupancy: push and pop in the same cycle leave the count unchanged
   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CW'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   // Storage and pointers; reset discards all buffered results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= ptr_next(wr_q);
         end
         if (pop_ok) begin
            rd_q <= ptr_next(rd_q);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/icdf_scheduler.sv
// rtl/icdf_scheduler.sv - round-robin sharing of one fixed-latency inverse-CDF pipeline
module icdf_scheduler
   import icdf_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int WIDTH      = 32,
   parameter int FRAC       = 16,
   parameter int LAT        = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_u,
   output logic [NREQ-1:0]         req_ready,
   output logic                    pipe_valid_in,
   output logic [WIDTH-1:0]        pipe_u,
   input  logic                    pipe_valid_out,
   input  logic [WIDTH-1:0]        pipe_z,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(NREQ)-1:0] out_id,
   output logic [WIDTH-1:0]        out_z,
   output logic                    err
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   if (FIFO_DEPTH < LAT + 1) begin : g_depth_chk
      $error("icdf_scheduler: FIFO_DEPTH must be at least LAT+1");
   end
   if (LAT < 1 || NREQ < 2) begin : g_geom_chk
      $error("icdf_scheduler: LAT must be >= 1 and NREQ >= 2");
   end
   if (WIDTH != ICDF_WIDTH || $clog2(NREQ) != IDW || FRAC >= WIDTH) begin : g_pkg_chk
      $error("icdf_scheduler: parameters disagree with icdf_pkg types");
   end

   logic [WIDTH-1:0] req_u_a [NREQ];
   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign req_u_a[g] = req_u[g*WIDTH +: WIDTH];
   end

   logic [IDW-1:0]   ptr_q, ptr_d, grant_id, issue_id_q;
   logic [IDW:0]     cand;
   logic             grant_any, pop;
   logic [CW-1:0]    credits_q, credits_d;
   logic             pipe_valid_q, err_q;
   logic [WIDTH-1:0] pipe_u_q;
   icdf_tag_t        tag_q [LAT];
   icdf_tag_t        tag_out;
   icdf_res_t        push_res, head_res;
   logic [RESW-1:0]  fifo_head;
   logic             fifo_empty;

   // Round-robin arbiter: first valid requester at or after ptr, only while credits remain
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      req_ready = '0;
      ptr_d     = ptr_q;
      if (credits_q != '0) begin
         for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
               cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_any && req_valid[cand[IDW-1:0]]) begin
               grant_any = 1'b1;
               grant_id  = cand[IDW-1:0];
            end
         end
      end
      if (grant_any) begin
         req_ready[grant_id] = 1'b1;
         ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
   end

   // Credits count free FIFO slots minus samples already in flight
   always_comb begin
      credits_d = credits_q;
      if (grant_any && !pop) begin
         credits_d = credits_q - CW'(1);
      end else if (!grant_any && pop) begin
         credits_d = credits_q + CW'(1);
      end
   end

   // Arbiter pointer, credit counter and issue register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q        <= '0;
         credits_q    <= CW'(FIFO_DEPTH);
         pipe_valid_q <= 1'b0;
         pipe_u_q     <= '0;
         issue_id_q   <= '0;
      end else begin
         ptr_q        <= ptr_d;
         credits_q    <= credits_d;
         pipe_valid_q <= grant_any;
         if (grant_any) begin
            pipe_u_q   <= req_u_a[grant_id];
            issue_id_q <= grant_id;
         end
      end
   end

   // Tag line mirrors the pipeline so each result can be re-associated with its requester
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         tag_q[0] <= icdf_tag_t'{vld: pipe_valid_q, id: issue_id_q};
         for (int k = 1; k < LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   assign tag_out = tag_q[LAT-1];

   // Sticky flag when the pipeline strobe and the tag line disagree
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (pipe_valid_out != tag_out.vld) begin
         err_q <= 1'b1;
      end
   end

   // Retirement is driven by the tag line alone, never by the pipeline strobe
   assign push_res.id = tag_out.id;
   assign push_res.z  = pipe_z;

   icdf_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tag_out.vld),
      .push_data (push_res),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty)
   );

   assign head_res      = fifo_head;
   assign out_valid     = !fifo_empty;
   assign pop           = out_valid && out_ready;
   assign out_id        = head_res.id;
   assign out_z         = head_res.z;
   assign pipe_valid_in = pipe_valid_q;
   assign pipe_u        = pipe_u_q;
   assign err           = err_q;

endmodule

// File: tb/tb_icdf_scheduler.sv
// tb/tb_icdf_scheduler.sv - self-checking bench for icdf_scheduler
module tb_icdf_scheduler;

   localparam int NREQ       = 4;
   localparam int WIDTH      = 32;
   localparam int LAT        = 4;
   localparam int FIFO_DEPTH = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_u;
   logic [NREQ-1:0]       req_ready;
   logic                  pipe_valid_in;
   logic [WIDTH-1:0]      pipe_u;
   logic                  pipe_valid_out;
   logic [WIDTH-1:0]      pipe_z;
   logic                  out_valid;
   logic                  out_ready;
   logic [1:0]            out_id;
   logic [WIDTH-1:0]      out_z;
   logic                  err;

   icdf_scheduler #(
      .NREQ       (NREQ),
      .WIDTH      (WIDTH),
      .FRAC       (16),
      .LAT        (LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_u          (req_u),
      .req_ready      (req_ready),
      .pipe_valid_in  (pipe_valid_in),
      .pipe_u         (pipe_u),
      .pipe_valid_out (pipe_valid_out),
      .pipe_z         (pipe_z),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_id         (out_id),
      .out_z          (out_z),
      .err            (err)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] zfun(input logic [WIDTH-1:0] u);
      return u ^ 32'h5A5A_0F0F;
   endfunction

   // Inverse-CDF pipeline stand-in: fixed LAT, shares rst, optional stray strobe
   logic             pv [LAT];
   logic [WIDTH-1:0] pz [LAT];
   logic             inject;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin
            pv[k] <= 1'b0;
            pz[k] <= '0;
         end
      end else begin
         pv[0] <= pipe_valid_in;
         pz[0] <= zfun(pipe_u);
         for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pz[k] <= pz[k-1];
         end
      end
   end
   assign pipe_valid_out = pv[LAT-1] | inject;
   assign pipe_z         = pz[LAT-1];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cnt  = 0;
   int pop_cnt  = 0;
   int first_pop = -1;
   int last_pop  = -1;
   int first_ov  = -1;
   logic             vary_u = 1'b0;
   logic [1:0]       q_id [$];
   logic [WIDTH-1:0] q_z  [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: accepted samples in issue order against every presented result
   always @(negedge clk) begin
      if (rst) begin
         q_id.delete();
         q_z.delete();
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               q_id.push_back(2'(i));
               q_z.push_back(zfun(req_u[i*WIDTH +: WIDTH]));
               acc_cnt++;
            end
         end
         if (out_valid) begin
            if (first_ov < 0) first_ov = cyc;
            if (q_id.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL out_unexpected: got id %0d z %0h expected no result", out_id, out_z);
            end else begin
               check("out_id", out_id, q_id[0]);
               check("out_z", out_z, q_z[0]);
               if (out_ready) begin
                  void'(q_id.pop_front());
                  void'(q_z.pop_front());
                  pop_cnt++;
                  if (first_pop < 0) first_pop = cyc;
                  last_pop = cyc;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (vary_u) begin
         for (int i = 0; i < NREQ; i++) begin
            req_u[i*WIDTH +: WIDTH] = ($urandom() & 32'h0000_FFFF) | 32'h1;
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int k;
      for (k = 0; k < 200; k++) begin
         sample();
         if (q_id.size() == 0 && !out_valid && !pipe_valid_in) break;
      end
      check(name, 64'(k < 200), 64'd1);
      step();
   endtask

   task automatic wait_accepts(input string name, input int base, input int n);
      int k;
      for (k = 0; k < 60; k++) begin
         sample();
         if (acc_cnt - base >= n) break;
         step();
      end
      check(name, 64'(acc_cnt - base), 64'(n));
      step();
   endtask

   typedef struct {
      logic [3:0] valid;
      logic [3:0] grant;
   } vec_t;

   vec_t vecs [12];
   int   c0, base, pbase;

   initial begin
      vecs[0]  = '{4'b1111, 4'b0001};
      vecs[1]  = '{4'b1111, 4'b0010};
      vecs[2]  = '{4'b1111, 4'b0100};
      vecs[3]  = '{4'b1111, 4'b1000};
      vecs[4]  = '{4'b0000, 4'b0000};
      vecs[5]  = '{4'b1010, 4'b0010};
      vecs[6]  = '{4'b0011, 4'b0001};
      vecs[7]  = '{4'b0100, 4'b0100};
      vecs[8]  = '{4'b0100, 4'b0100};
      vecs[9]  = '{4'b1001, 4'b1000};
      vecs[10] = '{4'b1001, 4'b0001};
      vecs[11] = '{4'b0000, 4'b0000};

      rst       = 1'b1;
      req_valid = '0;
      req_u     = {32'h0000_0001, 32'h0000_C000, 32'h0000_8000, 32'h0000_4000};
      out_ready = 1'b1;
      inject    = 1'b0;
      c0        = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_pipe_valid_in", pipe_valid_in, 0);
      check("rst_pipe_u", pipe_u, 0);
      check("rst_out_id", out_id, 0);
      check("rst_out_z", out_z, 0);
      check("rst_err", err, 0);
      check("rst_credits", dut.credits_q, FIFO_DEPTH);
      step();
      rst = 1'b0;

      // 1: arbitration vectors from ptr=0, plus first-result latency
      for (int v = 0; v < 12; v++) begin
         req_valid = vecs[v].valid;
         sample();
         if (v == 0) c0 = cyc;
         check($sformatf("t1_grant_%0d", v), req_ready, vecs[v].grant);
         step();
      end
      req_valid = '0;
      wait_drain("t1_drain");
      check("t1_latency", 64'(first_ov - c0), 64'(LAT + 2));
      check("t1_err", err, 0);

      // 2: single requester re-granted every cycle, results back-to-back
      vary_u    = 1'b1;
      first_pop = -1;
      pbase     = pop_cnt;
      req_valid = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         sample();
         check($sformatf("t2_grant_%0d", k), req_ready, 4'b0100);
         step();
      end
      req_valid = '0;
      wait_drain("t2_drain");
      check("t2_pops", 64'(pop_cnt - pbase), 64'd10);
      check("t2_no_gaps", 64'(last_pop - first_pop), 64'd9);

      // 3: backpressure stops issue after FIFO_DEPTH, release loses nothing
      out_ready = 1'b0;
      base      = acc_cnt;
      pbase     = pop_cnt;
      req_valid = 4'b1111;
      repeat (FIFO_DEPTH + LAT + 6) step();
      sample();
      check("t3_issues", 64'(acc_cnt - base), 64'(FIFO_DEPTH));
      check("t3_ready_off", req_ready, 0);
      check("t3_credits", dut.credits_q, 0);
      check("t3_fifo_count", dut.u_fifo.count_q, FIFO_DEPTH);
      step();
      req_valid = '0;
      out_ready = 1'b1;
      wait_drain("t3_drain");
      check("t3_pops", 64'(pop_cnt - pbase), 64'(FIFO_DEPTH));
      check("t3_credits_back", dut.credits_q, FIFO_DEPTH);

      // 4: issue and pop together while credits == 1
      out_ready = 1'b0;
      base      = acc_cnt;
      req_valid = 4'b1111;
      wait_accepts("t4_fill", base, FIFO_DEPTH - 1);
      req_valid = '0;
      repeat (LAT + 3) step();
      sample();
      check("t4_credits_pre", dut.credits_q, 1);
      check("t4_count_pre", dut.u_fifo.count_q, FIFO_DEPTH - 1);
      step();
      req_valid = 4'b0010;
      out_ready = 1'b1;
      sample();
      check("t4_grant", req_ready, 4'b0010);
      check("t4_out_valid", out_valid, 1);
      step();
      req_valid = '0;
      out_ready = 1'b0;
      sample();
      check("t4_credits_post", dut.credits_q, 1);
      check("t4_count_post", dut.u_fifo.count_q, FIFO_DEPTH - 2);
      step();
      out_ready = 1'b1;
      wait_drain("t4_drain");

      // 5: stray pipeline strobe sets err, pushes nothing, only rst clears it
      inject = 1'b1;
      sample();
      check("t5_err_before", err, 0);
      step();
      inject = 1'b0;
      sample();
      check("t5_err_set", err, 1);
      check("t5_no_push", out_valid, 0);
      repeat (5) step();
      sample();
      check("t5_err_sticky", err, 1);
      step();
      rst = 1'b1;
      sample();
      check("t5_err_cleared", err, 0);
      step();
      rst = 1'b0;

      // 6: reset with 2 buffered and 3 in flight
      out_ready = 1'b0;
      base      = acc_cnt;
      req_valid = 4'b0001;
      wait_accepts("t6_fill_a", base, 2);
      req_valid = '0;
      repeat (LAT + 3) step();
      sample();
      check("t6_buffered", dut.u_fifo.count_q, 2);
      step();
      req_valid = 4'b1111;
      wait_accepts("t6_fill_b", base, 5);
      rst       = 1'b1;
      req_valid = '0;
      sample();
      check("t6_out_valid", out_valid, 0);
      check("t6_req_ready", req_ready, 0);
      check("t6_credits", dut.credits_q, FIFO_DEPTH);
      step();
      rst       = 1'b0;
      req_valid = 4'b1111;
      sample();
      check("t6_first_grant", req_ready, 4'b0001);
      step();
      req_valid = '0;
      out_ready = 1'b1;
      wait_drain("t6_drain");
      check("t6_err", err, 0);
      check("t6_credits_end", dut.credits_q, FIFO_DEPTH);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
